// File: rtl/id_stage_if.sv
// id_stage_if: bundles every id_stage signal except clock and reset.
//   Fetch side     : in_valid_i, in_ready_o, instr_i, pc_i
//   Register file  : rs1_addr_o, rs2_addr_o, rs1_data_i, rs2_data_i
//   Writeback      : wb_valid_i, wb_rd_i
//   Execute side   : out_valid_o, out_ready_i, alu_op_o, alu_alt_o,
//                    operand1_o, operand2_o, rd_o, rd_we_o, illegal_o
// Signal names keep the stage-relative _i/_o suffixes of the original ports.
// Modports: slave = the decode stage itself, master = its environment.
interface id_stage_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  alu_op_o;
    logic        alu_alt_o;
    logic [31:0] operand1_o;
    logic [31:0] operand2_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic        illegal_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
               wb_valid_i, wb_rd_i, out_ready_i,
        output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, alu_op_o,
               alu_alt_o, operand1_o, operand2_o, rd_o, rd_we_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
               wb_valid_i, wb_rd_i, out_ready_i,
        input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, alu_op_o,
               alu_alt_o, operand1_o, operand2_o, rd_o, rd_we_o, illegal_o
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage for OP, OP-IMM, LUI and AUIPC.
// Decodes instr_i combinationally, reads register operands in the same
// cycle and registers the decoded ALU request with a valid/ready handshake
// (1-cycle latency, full throughput). Unsupported words pass through with
// illegal_o set and rd_we_o cleared.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   bus    : id_stage_if.slave (fetch, register file, writeback, execute)
// Build option: define ID_SCOREBOARD_EN to enable the busy-register
// scoreboard that stalls on RAW hazards until writeback; when undefined
// there is no busy state and the writeback inputs are ignored.
module id_stage (
    input logic       clk_i,
    input logic       rst_ni,
    id_stage_if.slave bus
);
    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SR   = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign instr  = bus.instr_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.rs1_addr_o = rs1;
    assign bus.rs2_addr_o = rs2;

    logic        is_op;
    logic        is_op_imm;
    logic        dec_illegal;
    logic        dec_alt;
    logic [2:0]  dec_op;
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [4:0]  dec_rd;
    logic        dec_we;

    always_comb begin
        is_op       = 1'b0;
        is_op_imm   = 1'b0;
        dec_illegal = 1'b0;
        dec_alt     = 1'b0;
        dec_op      = ALU_ADD;
        dec_op1     = '0;
        dec_op2     = '0;
        case (opcode)
            OPC_OP: begin
                is_op   = 1'b1;
                dec_op  = funct3;
                dec_alt = instr[30];
                dec_op1 = bus.rs1_data_i;
                dec_op2 = bus.rs2_data_i;
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == ALU_ADD || funct3 == ALU_SR))))
                    dec_illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                is_op_imm = 1'b1;
                dec_op    = funct3;
                dec_op1   = bus.rs1_data_i;
                if (funct3 == ALU_SLL || funct3 == ALU_SR) begin
                    // Shift amount lives in the low 5 bits of the immediate.
                    dec_op2 = {27'b0, instr[24:20]};
                    if (funct3 == ALU_SR) begin
                        dec_alt = instr[30];
                        if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                            dec_illegal = 1'b1;
                    end else if (funct7 != 7'b0000000) begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    dec_op2 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LUI: begin
                dec_op2 = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec_op1 = bus.pc_i;
                dec_op2 = {instr[31:12], 12'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_rd = instr[11:7];
    assign dec_we = !dec_illegal && (dec_rd != 5'd0);

    logic hazard;
    logic in_ready;
    logic accept;
    logic out_valid_q;

    assign in_ready       = !hazard && (!out_valid_q || bus.out_ready_i);
    assign accept         = bus.in_valid_i && in_ready;
    assign bus.in_ready_o = in_ready;

`ifdef ID_SCOREBOARD_EN
    logic        reads_rs1;
    logic        reads_rs2;
    logic [31:1] busy_q;
    logic [31:0] busy;

    // Illegal words never read registers, so they never stall.
    assign reads_rs1 = (is_op || is_op_imm) && !dec_illegal;
    assign reads_rs2 = is_op && !dec_illegal;
    assign busy      = {busy_q, 1'b0};
    assign hazard    = bus.in_valid_i &&
                       ((reads_rs1 && busy[rs1]) || (reads_rs2 && busy[rs2]));

    // A new issue to a register outranks a writeback of the same register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (accept && dec_we && dec_rd == 5'(i))
                    busy_q[i] <= 1'b1;
                else if (bus.wb_valid_i && bus.wb_rd_i == 5'(i))
                    busy_q[i] <= 1'b0;
            end
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{bus.wb_valid_i, bus.wb_rd_i, is_op, is_op_imm};
    assign hazard    = 1'b0;
`endif

    logic [2:0]  alu_op_q;
    logic        alu_alt_q;
    logic [31:0] operand1_q;
    logic [31:0] operand2_q;
    logic [4:0]  rd_q;
    logic        rd_we_q;
    logic        illegal_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_alt_q   <= 1'b0;
            operand1_q  <= '0;
            operand2_q  <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_op_q    <= dec_op;
            alu_alt_q   <= dec_alt;
            operand1_q  <= dec_op1;
            operand2_q  <= dec_op2;
            rd_q        <= dec_rd;
            rd_we_q     <= dec_we;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.alu_op_o    = alu_op_q;
    assign bus.alu_alt_o   = alu_alt_q;
    assign bus.operand1_o  = operand1_q;
    assign bus.operand2_o  = operand2_q;
    assign bus.rd_o        = rd_q;
    assign bus.rd_we_o     = rd_we_q;
    assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
// Covers reset values, decode of OP/OP-IMM/LUI/AUIPC and illegal words,
// mid-operation reset, output back-pressure and (with ID_SCOREBOARD_EN)
// RAW stalls released by writeback.
module tb_id_stage;
    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    id_stage_if bus ();

    id_stage dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction, expect it accepted this cycle, then check the
    // registered result one edge later. Operands/op are skipped for illegal words.
    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [2:0] op, input logic alt,
                         input logic [31:0] o1, input logic [31:0] o2,
                         input logic [4:0] rd, input logic we, input logic ill);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = ins;
        bus.pc_i       = pc;
        bus.rs1_data_i = d1;
        bus.rs2_data_i = d2;
        #1;
        check({tag, ".rdy"},  32'(bus.in_ready_o), 32'd1);
        check({tag, ".rs1a"}, 32'(bus.rs1_addr_o), 32'(ins[19:15]));
        check({tag, ".rs2a"}, 32'(bus.rs2_addr_o), 32'(ins[24:20]));
        @(posedge clk_i); #1;
        bus.in_valid_i = 1'b0;
        check({tag, ".vld"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, ".rd"},  32'(bus.rd_o),        32'(rd));
        check({tag, ".we"},  32'(bus.rd_we_o),     32'(we));
        check({tag, ".ill"}, 32'(bus.illegal_o),   32'(ill));
        if (!ill) begin
            check({tag, ".op"},  32'(bus.alu_op_o),  32'(op));
            check({tag, ".alt"}, 32'(bus.alu_alt_o), 32'(alt));
            check({tag, ".op1"}, bus.operand1_o,     o1);
            check({tag, ".op2"}, bus.operand2_o,     o2);
        end
    endtask

    initial begin
        rst_ni          = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.pc_i        = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.wb_valid_i  = 1'b0;
        bus.wb_rd_i     = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.vld", 32'(bus.out_valid_o), 32'd0);
        check("rst.op1", bus.operand1_o, 32'd0);
        check("rst.op2", bus.operand2_o, 32'd0);
        check("rst.rd",  32'(bus.rd_o), 32'd0);
        check("rst.we",  32'(bus.rd_we_o), 32'd0);
        check("rst.ill", 32'(bus.illegal_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        check("rst.rdy", 32'(bus.in_ready_o), 32'd1);

        // Back-to-back decode vectors, execute always ready
        issue("add",    32'h002081B3, 32'h0, 32'd5, 32'd7, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        issue("srai",   32'h41F0D213, 32'h0, 32'h80000000, 32'h0, 3'b101, 1'b1, 32'h80000000, 32'h1F, 5'd4, 1'b1, 1'b0);
        issue("sub",    32'h402082B3, 32'h0, 32'd9, 32'd4, 3'b000, 1'b1, 32'd9, 32'd4, 5'd5, 1'b1, 1'b0);
        issue("sll_f7", 32'h402091B3, 32'h0, 32'd1, 32'd2, 3'b000, 1'b0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);
        issue("slli_f7",32'h40509393, 32'h0, 32'd1, 32'd2, 3'b000, 1'b0, 32'd0, 32'd0, 5'd7, 1'b0, 1'b1);
        issue("add_x0", 32'h00208033, 32'h0, 32'd1, 32'd2, 3'b000, 1'b0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
        issue("ori",    32'h8000E113, 32'h0, 32'h1234, 32'h0, 3'b110, 1'b0, 32'h1234, 32'hFFFFF800, 5'd2, 1'b1, 1'b0);
        issue("addi",   32'hFFF00093, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
        issue("auipc",  32'h12345297, 32'h100, 32'h0, 32'h0, 3'b000, 1'b0, 32'h100, 32'h12345000, 5'd5, 1'b1, 1'b0);
        issue("zero",   32'h00000000, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        issue("lui",    32'hABCDE337, 32'h40, 32'hDEAD, 32'h0, 3'b000, 1'b0, 32'h0, 32'hABCDE000, 5'd6, 1'b1, 1'b0);
        issue("lowbits",32'h002081B0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        check("drain.vld", 32'(bus.out_valid_o), 32'd0);

        // Reset while an output is held discards it
        bus.out_ready_i = 1'b0;
        issue("hold",   32'hABCDE337, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 32'hABCDE000, 5'd6, 1'b1, 1'b0);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("midrst.vld", 32'(bus.out_valid_o), 32'd0);
        check("midrst.op2", bus.operand2_o, 32'd0);
        check("midrst.rd",  32'(bus.rd_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        check("midrst.rdy", 32'(bus.in_ready_o), 32'd1);

        // Back-pressure: A held for 3 cycles while B waits, then both move
        issue("bp.a",   32'h002081B3, 32'h0, 32'd5, 32'd7, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'hABCDE337;
        bus.rs1_data_i = 32'h0;
        bus.rs2_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.rdy", 32'(bus.in_ready_o), 32'd0);
            @(posedge clk_i); #1;
            check("bp.vld", 32'(bus.out_valid_o), 32'd1);
            check("bp.op1", bus.operand1_o, 32'd5);
            check("bp.op2", bus.operand2_o, 32'd7);
            check("bp.rd",  32'(bus.rd_o), 32'd3);
        end
        bus.out_ready_i = 1'b1;
        #1;
        check("bp.go.rdy", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk_i); #1;
        bus.in_valid_i = 1'b0;
        check("bp.b.vld", 32'(bus.out_valid_o), 32'd1);
        check("bp.b.op1", bus.operand1_o, 32'd0);
        check("bp.b.op2", bus.operand2_o, 32'hABCDE000);
        check("bp.b.rd",  32'(bus.rd_o), 32'd6);
        @(posedge clk_i); #1;
        check("bp.end.vld", 32'(bus.out_valid_o), 32'd0);

        // Clear any busy state before the hazard checks
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        issue("sb.add3", 32'h002081B3, 32'h0, 32'd5, 32'd7, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
`ifdef ID_SCOREBOARD_EN
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'h00318233;
        #1;
        check("sb.stall0.rdy", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk_i); #1;
        check("sb.stall1.vld", 32'(bus.out_valid_o), 32'd0);
        check("sb.stall1.rdy", 32'(bus.in_ready_o), 32'd0);
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        #1;
        check("sb.wb.rdy", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk_i); #1;
        bus.wb_valid_i = 1'b0;
        issue("sb.add4", 32'h00318233, 32'h0, 32'd3, 32'd3, 3'b000, 1'b0, 32'd3, 32'd3, 5'd4, 1'b1, 1'b0);
        // Writeback of x3 on the same edge as a new x3 issue: x3 stays busy
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        issue("sb.reissue", 32'h002081B3, 32'h0, 32'd1, 32'd1, 3'b000, 1'b0, 32'd1, 32'd1, 5'd3, 1'b1, 1'b0);
        bus.wb_valid_i = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.instr_i    = 32'h00018393;
        #1;
        check("sb.setwins.rdy", 32'(bus.in_ready_o), 32'd0);
        bus.wb_valid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.wb_valid_i = 1'b0;
        issue("sb.addi7", 32'h00018393, 32'h0, 32'h77, 32'h0, 3'b000, 1'b0, 32'h77, 32'h0, 5'd7, 1'b1, 1'b0);
`else
        // Without the scoreboard a dependent instruction never stalls
        bus.wb_valid_i = 1'b1;
        bus.wb_rd_i    = 5'd3;
        issue("nosb.add4", 32'h00318233, 32'h0, 32'd3, 32'd3, 3'b000, 1'b0, 32'd3, 32'd3, 5'd4, 1'b1, 1'b0);
        bus.wb_valid_i = 1'b0;
        issue("nosb.addi7", 32'h00018393, 32'h0, 32'h77, 32'h0, 3'b000, 1'b0, 32'h77, 32'h0, 5'd7, 1'b1, 1'b0);
`endif
        @(posedge clk_i); #1;
        check("end.vld", 32'(bus.out_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
- REQ-001 SHALL: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-002 SHALL: rst_ni  in  1  reset, synchronous, active-low.
- REQ-003 SHALL: in_valid_i  in  1  fetch presents an instruction.
- REQ-004 SHALL: in_ready_o  out  1  stage accepts; transfer when in_valid_i && in_ready_o.
- REQ-005 SHALL: instr_i  in  32  RV32I instruction word.
- REQ-006 SHALL: pc_i  in  32  address of instr_i.
- REQ-007 SHALL: rs1_addr_o  out  5  register-file read address, equals instr_i[19:15], combinational.
- REQ-008 SHALL: rs2_addr_o  out  5  register-file read address, equals instr_i[24:20], combinational.
- REQ-009 SHALL: rs1_data_i  in  32  same-cycle read data for rs1_addr_o.
- REQ-010 SHALL: rs2_data_i  in  32  same-cycle read data for rs2_addr_o.
- REQ-011 SHALL: wb_valid_i  in  1  writeback of wb_rd_i completes this cycle.
- REQ-012 SHALL: wb_rd_i  in  5  destination register being written back.
- REQ-013 SHALL: out_valid_o  out  1  registered decoded instruction valid toward ALU.
- REQ-014 SHALL: out_ready_i  in  1  execute consumes; transfer when out_valid_o && out_ready_i.
- REQ-015 SHALL: alu_op_o  out  3  ALU funct3 select (ADD/SLL/SLT/SLTU/XOR/SR/OR/AND encodings).
- REQ-016 SHALL: alu_alt_o  out  1  SUB/SRA select.
- REQ-017 SHALL: operand1_o  out  32  ALU first operand.
- REQ-018 SHALL: operand2_o  out  32  ALU second operand.
- REQ-019 SHALL: rd_o  out  5  destination register.
- REQ-020 SHALL: rd_we_o  out  1  result written to rd_o.
- REQ-021 SHALL: illegal_o  out  1  decoded word unsupported/malformed.

Function
- REQ-022 SHALL: latency exactly 1 cycle, accept at edge N -> out_valid_o high after edge N; all out_* registered and held stable while out_valid_o && !out_ready_i.
- REQ-023 SHALL: in_ready_o = !hazard && (!out_valid_o || out_ready_i); accept and drain in the same cycle sustains 1 instr/cycle.
- REQ-024 SHALL: OP (0110011): op=funct3, alt=instr[30], operand1=rs1_data_i, operand2=rs2_data_i; funct7 SHALL be 0000000, or 0100000 only with funct3 000/101, else illegal.
- REQ-025 SHALL: OP-IMM (0010011): operand2=sign-extended instr[31:20]; alt=0 except funct3 101 where alt=instr[30]; shifts operand2={27'b0,instr[24:20]}; SLLI funct7≠0000000, SRLI/SRAI funct7 not 0000000/0100000 -> illegal.
- REQ-026 SHALL: LUI: op=ADD, alt=0, operand1=0, operand2={instr[31:12],12'b0}; AUIPC: same but operand1=pc_i.
- REQ-027 SHALL: any other opcode, or instr[1:0]≠11 -> illegal_o=1, rd_we_o=0, operands don't-care, instruction still passes with out_valid_o.
- REQ-028 SHALL: rd_we_o=1 only for legal instructions with rd≠0.
- REQ-029 SHALL: scoreboard busy[31:1] set for rd_o on output-register load with rd_we; cleared on wb_valid_i for wb_rd_i; same-register set and clear in same cycle -> set wins; busy[0] constant 0; wb for non-busy register ignored.
- REQ-030 SHALL: hazard = in_valid_i && ((reads rs1 && busy[rs1]) || (OP && busy[rs2])); LUI/AUIPC/illegal never hazard.

Reset
- REQ-031 SHALL: while rst_ni low at an edge: out_valid_o=0, busy cleared, all out_* data=0, in_ready_o=1 first cycle after reset.
- REQ-032 SHALL: reset mid-operation discards any held output instruction without handshake.

Configuration
- REQ-033 SHALL: ID_SCOREBOARD_EN defined -> REQ-029/030 active; undefined -> no busy state, hazard=0, wb_valid_i/wb_rd_i ignored, all other behaviour identical.

Verification
- REQ-034 SHALL: ADD x3,x1,x2 with rs1_data=5, rs2_data=7 -> next cycle out_valid=1, op=000, alt=0, operands 5/7, rd=3, rd_we=1.
- REQ-035 SHALL: SRAI x4,x1,31 (0x41F0D213) -> op=101, alt=1, operand2=0x1F; ADDI x1,x0,-1 -> operand2=0xFFFFFFFF.
- REQ-036 SHALL: AUIPC x5,0x12345, pc=0x100 -> operand1=0x100, operand2=0x12345000; word 0x00000000 -> illegal_o=1, rd_we=0.
- REQ-037 SHALL: out_ready_i low 3 cycles with in_valid_i high -> outputs stable, in_ready_o=0, no instruction lost or duplicated.
- REQ-038 SHALL: (ID_SCOREBOARD_EN) ADD x3 issued then ADD x4,x3,x3 -> in_ready_o=0 until wb_valid_i with wb_rd_i=3, accepted that cycle-after; wb of x3 coinciding with new x3 issue leaves x3 busy.
